// File: rtl/serial_word_tx_pkg.sv
// Shared types and constants for the serial word transmitter and its
// companions (shift-in register, adder top).
package serial_word_tx_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_tx_piso_reg.sv
// Parallel-load, shift-right register; LSB leaves first, zeros enter at the MSB.
// Mirror image of the shift-in register on the receiving side.
module piso_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;

  // Shift register: reset, then load, then shift priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {N{1'b0}};
    end else if (load) begin
      q_q <= d;
    end else if (shift) begin
      q_q <= {1'b0, q_q[N-1:1]};
    end else begin
      q_q <= q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter: LSB first, one ser_en strobe per
// bit period, one-cycle done pulse after the last bit.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int N          = WORD_W,
  parameter int BIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         load,
  output logic         ready,
  output logic         ser_bit,
  output logic         ser_en,
  output logic         done
);

  localparam int BW = $clog2(N);
  localparam int PW = cnt_w(BIT_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(BIT_CYCLES - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] per_q, per_d;
  logic [N-1:0]  shreg_s;
  logic          ready_s;
  logic          ser_en_s;
  logic          accept_s;

  assign ready_s  = (state_q == IDLE) || (state_q == DONE);
  assign ser_en_s = (state_q == SHIFT) && (per_q == PER_LAST);
  assign accept_s = load && ready_s;

  piso_reg #(.N(N)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .shift (ser_en_s),
    .d     (data_in),
    .q     (shreg_s)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= {BW{1'b0}};
      per_q   <= {PW{1'b0}};
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      per_q   <= per_d;
    end
  end

  // Next state; the bit counter holds at N-1 on exit so it never wraps.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    per_d   = per_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d = SHIFT;
          bit_d   = {BW{1'b0}};
          per_d   = {PW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (ser_en_s) begin
          per_d = {PW{1'b0}};
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          per_d = per_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        bit_d   = {BW{1'b0}};
        per_d   = {PW{1'b0}};
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    ready   = ready_s;
    ser_en  = ser_en_s;
    ser_bit = 1'b0;
    done    = 1'b0;
    case (state_q)
      SHIFT:   ser_bit = shreg_s[0];
      DONE:    done    = 1'b1;
      IDLE:    done    = 1'b0;
      default: ser_bit = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx with BIT_CYCLES = 1 and 4 instances;
// expected waveforms are derived from the start cycle of each accepted word.
module tb_serial_word_tx;
  import serial_word_tx_pkg::*;

  localparam int N = WORD_W;

  typedef struct {
    logic [31:0] word;
    int          start;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [N-1:0] d0 = '0, d1 = '0;
  logic         ld0 = 1'b0, ld1 = 1'b0;
  logic         rdy0, bit0, en0, dn0;
  logic         rdy1, bit1, en1, dn1;

  serial_word_tx #(.N(N), .BIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .data_in(d0), .load(ld0),
    .ready(rdy0), .ser_bit(bit0), .ser_en(en0), .done(dn0)
  );

  serial_word_tx #(.N(N), .BIT_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .data_in(d1), .load(ld1),
    .ready(rdy1), .ser_bit(bit1), .ser_en(en1), .done(dn1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_t       q0[$];
  frame_t       q1[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           mon_on = 1'b0;
  logic [N-1:0] rx[2];
  int           nb[2] = '{0, 0};
  int           abort_at[2] = '{32'h7fff_ffff, 32'h7fff_ffff};
  int           bcyc[2] = '{1, 4};

  function automatic void check(input int id, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s cycle=%0d actual=%h expected=%h", id, name, cyc, act, exp);
    end
  endfunction

  task automatic pop_front(input int id);
    if (id == 0) void'(q0.pop_front());
    else         void'(q1.pop_front());
  endtask

  task automatic mon_step(input int id, input logic en, input logic b,
                          input logic dn, input logic rdy);
    frame_t f;
    bit     have;
    int     rel;
    int     nbt;
    nbt  = N * bcyc[id];
    have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      f = (id == 0) ? q0[0] : q1[0];
      if (cyc >= abort_at[id]) begin
        pop_front(id);
        abort_at[id] = 32'h7fff_ffff;
        nb[id] = 0;
        have = 1'b0;
      end
    end
    if (have && cyc >= f.start) begin
      rel = cyc - f.start;
      check(id, "ser_en", 32'(en), 32'((rel < nbt) && (((rel + 1) % bcyc[id]) == 0)));
      check(id, "ser_bit", 32'(b), 32'((rel < nbt) ? f.word[rel / bcyc[id]] : 1'b0));
      check(id, "done", 32'(dn), 32'(rel == nbt));
      check(id, "ready", 32'(rdy), 32'(rel >= nbt));
      if (en) begin
        rx[id] = {b, rx[id][N-1:1]};
        nb[id]++;
      end
      if (rel >= nbt) begin
        check(id, "rx_word", rx[id], f.word);
        check(id, "strobe_count", nb[id], N);
        pop_front(id);
        nb[id] = 0;
      end
    end else begin
      check(id, "idle_ser_en", 32'(en), 32'd0);
      check(id, "idle_ser_bit", 32'(b), 32'd0);
      check(id, "idle_done", 32'(dn), 32'd0);
      check(id, "idle_ready", 32'(rdy), 32'd1);
    end
  endtask

  // Monitor: compares both instances against the scoreboard on every falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      mon_step(0, en0, bit0, dn0, rdy0);
      mon_step(1, en1, bit1, dn1, rdy1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int id, input logic [31:0] w);
    frame_t f;
    f.word  = w;
    f.start = cyc + 1;
    if (id == 0) begin
      d0 = w; ld0 = 1'b1; q0.push_back(f);
    end else begin
      d1 = w; ld1 = 1'b1; q1.push_back(f);
    end
    tick(1);
    ld0 = 1'b0;
    ld1 = 1'b0;
  endtask

  initial begin
    frame_t f2;
    logic [31:0] w;
    int id;

    rx[0] = '0;
    rx[1] = '0;
    tick(2);
    mon_on = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Single set bit, then loopback word, B=1.
    send(0, 32'h0000_0001); tick(N); tick(2);
    send(0, 32'hA5A5_5A5A); tick(N); tick(1);

    // B=4, upper half ones.
    send(1, 32'hFFFF_0000); tick(4 * N); tick(1);

    // Load while busy is ignored.
    send(0, 32'h1234_5678);
    tick(4);
    d0 = 32'hDEAD_BEEF; ld0 = 1'b1;
    tick(2);
    ld0 = 1'b0;
    tick(N - 6); tick(1);

    // Load held through the DONE cycle starts the next word at once.
    w = $urandom;
    f2.word  = 32'h0F0F_0F0F;
    f2.start = cyc + 1 + N + 1;
    d0 = w; ld0 = 1'b1;
    begin
      frame_t f1;
      f1.word = w; f1.start = cyc + 1;
      q0.push_back(f1);
    end
    q0.push_back(f2);
    tick(1);
    d0 = 32'h0F0F_0F0F;
    tick(N + 1);
    ld0 = 1'b0;
    tick(N); tick(1);

    // Reset mid-frame, with load also high so reset priority is exercised.
    send(0, $urandom);
    tick(9);
    rst = 1'b1; ld0 = 1'b1; d0 = 32'hFFFF_FFFF;
    abort_at[0] = cyc + 1;
    tick(1);
    rst = 1'b0; ld0 = 1'b0;
    tick(2);
    send(0, $urandom); tick(N); tick(1);

    // Random words on random instances, with gaps of 0..3 after DONE.
    repeat (8) begin
      id = int'($urandom_range(0, 1));
      w  = $urandom;
      send(id, w);
      tick(N * bcyc[id]);
      tick(int'($urandom_range(0, 3)));
    end
    tick(2 * 4 * N);

    check(0, "queue_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-in, serial-out word transmitter: accepts an N-bit word on a load handshake and shifts it out LSB first, one bit per bit period, with a one-cycle strobe per bit. It drives the serial end of the team's shift-in register: ser_bit connects to the register's w input and ser_en to its e input. After N strobes the register holds the transmitted word unchanged. The usual source of data_in is the adder sum or an instruction-memory word.

## Interface
- N, 32: word width; N ≥ 2.
- BIT_CYCLES, 1: clock cycles per serial bit; ≥ 1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  N  word to transmit; sampled only on an accepted load.
- load  input  1  request to transmit; accepted when sampled high with ready high.
- ready  output  1  high in IDLE and DONE.
- ser_bit  output  1  current serial bit (LSB first); 0 when not in SHIFT.
- ser_en  output  1  one-cycle strobe per bit; the receiver shifts ser_bit in on the edge ending this cycle.
- done  output  1  one-cycle pulse after the last bit.

## Operation
- Outputs are decoded from registered state only; there is no combinational input-to-output path.
- The state machine has three states:
  - IDLE → SHIFT on an accepted load.
  - SHIFT → DONE after the N-th ser_en cycle.
  - DONE → SHIFT if load is accepted in that cycle, otherwise DONE → IDLE.
- On accept:
  - the shift register captures data_in;
  - the bit counter is cleared to 0;
  - the period counter is cleared to 0.
- In SHIFT:
  - ser_bit = shreg[0].
  - The period counter counts 0..BIT_CYCLES-1; ser_en = (period == BIT_CYCLES-1).
  - On each ser_en edge: shreg shifts right by one with 0 filled at the MSB, the bit counter increments, and the period counter wraps to 0.
- Leaving SHIFT: the state goes to DONE on the edge where bit counter == N-1 and ser_en is high.
- DONE: done=1 and ready=1 for exactly one cycle.
- load while busy: load sampled in SHIFT is ignored; the word in flight is never altered.
- Counter widths: bit counter $clog2(N) bits, period counter max(1,$clog2(BIT_CYCLES)) bits. Neither counter may wrap other than as specified.

## Timing
- Cycle c is the interval following rising edge c. An accepted load is sampled at edge 0.
- ser_en is high in cycles kB-1 for k = 1..N, where B = BIT_CYCLES. Bit k-1 of the word is on ser_bit throughout that bit's period.
- done is high in cycle N·B. ready is low in cycles 0..N·B-1.
- For B=1, ser_en is high continuously in cycles 0..N-1.
- Back-to-back: a load sampled at the edge that ends the DONE cycle starts the next word immediately. There is no idle gap beyond the one DONE cycle.
- Reset values, from the first edge with rst high: state IDLE, ready=1, ser_bit=0, ser_en=0, done=0, shreg=0, counters=0.
- rst has priority over load.
- Reset mid-frame:
  - the frame is aborted;
  - no further ser_en is issued;
  - no done is issued;
  - the receiver keeps its partial word.

## Structure
- Shared package:
  - state typedef tx_state_t {IDLE, SHIFT, DONE};
  - default width constant WORD_W = 32, shared with the register/adder top.
- One sub-module, piso_reg: an N-bit parallel-load, shift-right register with load, shift and rst inputs and q output. It is the mirror of the shift-in register.
- The FSM and both counters live in serial_word_tx.

## Test plan
- Reset, then load data_in=0x0000_0001 with B=1:
  - ser_en is high in cycles 0..31;
  - ser_bit=1 in cycle 0 and 0 in cycles 1..31;
  - done is high in cycle 32.
- Loopback into the shift-in register: send 0xA5A5_5A5A with B=1. After done, register q = 0xA5A5_5A5A.
- B=4, send 0xFFFF_0000:
  - 32 ser_en pulses in cycles 3, 7, …, 127;
  - ser_bit is 0 for the first 16 bits and 1 for the last 16;
  - done is high in cycle 128.
- Send 0x1234_5678, and in cycle 5 assert load with data_in=0xDEAD_BEEF. The load is ignored and the register receives 0x1234_5678.
- Hold load high through the DONE cycle with a new word 0x0F0F_0F0F (B=1). The second word's first ser_en occurs in cycle 33, and done occurs again in cycle 65.
- Assert rst at edge 10 mid-frame:
  - ser_en and done are 0 from cycle 10;
  - ready=1;
  - a subsequent load transmits a full word normally.
